// File: rtl/out_stream_fifo.sv
// First-word-fall-through buffer between a non-stalling producer and a stallable consumer.
// Words offered while full are dropped and latched into a sticky overflow flag.
module out_stream_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [ADDR_W:0]              wr_ptr, rd_ptr;
  logic                         full, empty, wr_en, rd_en;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign wr_en     = in_valid && !full;
  assign rd_en     = out_ready && !empty;
  assign out_data  = mem[rd_ptr[ADDR_W-1:0]];
  assign count     = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[ADDR_W-1:0]] <= in_data;
        wr_ptr                  <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A fresh drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   overflow <= 1'b0;
    else if (in_valid && full) overflow <= 1'b1;
    else if (clr_ovf)          overflow <= 1'b0;
  end

endmodule

// File: tb/tb_out_stream_fifo.sv
// Scoreboard bench for out_stream_fifo: directed pushes queue expected words,
// a negedge monitor pops and compares every accepted output word.
module tb_out_stream_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       overflow;
  logic       clr_ovf;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  out_stream_fifo #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Inputs are stable from posedge+1 to the next posedge, so a handshake seen
  // at negedge is exactly the transfer that the coming edge performs.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_word: got %02h, required no word (scoreboard empty)", out_data);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL out_word: got %02h, required %02h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) push(8'(i));
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);

    // 1: single word, one-cycle latency
    push(8'h11);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 8'h11);
    chk("t1_count", count, 1);
    drain(1);
    chk("t1_count_after", count, 0);

    // 2: fill to full, drain in order
    fill(8);
    chk("t2_count_full", count, 8);
    chk("t2_in_ready_full", in_ready, 0);
    drain(8);
    chk("t2_out_valid_empty", out_valid, 0);
    chk("t2_count_empty", count, 0);

    // 3: overflow on full, 0xAA must never appear, then clear
    fill(8);
    in_valid = 1'b1; in_data = 8'hAA;
    cyc();
    in_valid = 1'b0;
    chk("t3_overflow", overflow, 1);
    chk("t3_count", count, 8);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("t3_overflow_clr", overflow, 0);
    drain(8);
    chk("t3_count_drained", count, 0);

    // 4: streaming with pointer wrap (32 words through 8 entries)
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      push(8'(i));
      chk("t4_count_le1", (count <= 1), 1);
    end
    cyc();
    out_ready = 1'b0;
    chk("t4_count_end", count, 0);

    // 5: full with read and offered word in same cycle
    fill(8);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    cyc();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("t5_overflow", overflow, 1);
    chk("t5_count", count, 7);
    push(8'h09);
    chk("t5_count_refull", count, 8);
    clr_ovf = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    cyc();
    clr_ovf = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("t5_set_wins", overflow, 1);
    chk("t5_count2", count, 7);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("t5_overflow_clr", overflow, 0);
    drain(7);
    chk("t5_count_drained", count, 0);

    // 6: asynchronous reset mid-stream discards contents
    fill(3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_count", count, 0);
    chk("t6_out_data", out_data, 8'h00);
    chk("t6_in_ready", in_ready, 1);
    exp_q.delete();
    cyc();
    rst = 1'b0;
    push(8'h42);
    chk("t6_head", out_data, 8'h42);
    drain(1);
    chk("t6_count_end", count, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
